hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the select of the control-unit bubble mux.
- Generates the PC, IF/ID and ID/EX enables, plus the IF/ID flush, for the ARM-subset 5-stage pipeline.
- Detects load-use hazards and inserts a programmable number of bubbles.
- Freezes the pipe while data memory is busy, flushes IF/ID on taken branches, and keeps a saturating bubble counter for performance debug.

Parameters:
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rn  in  4  ID-stage Rn source register.
- id_rm  in  4  ID-stage Rm source register.
- id_rd  in  4  ID-stage Rd; read as a source for stores.
- id_use_rn, id_use_rm, id_use_rd  in  1 each  source-valid qualifiers.
- ex_load  in  1  EX-stage instruction is a load.
- ex_rf_en  in  1  EX-stage instruction writes the register file.
- ex_rd  in  4  EX-stage destination register.
- branch_taken  in  1  ID-stage branch resolved taken.
- mem_wait  in  1  data memory not ready; freeze pipe.
- cu_mux_sel  out  1  1 = bubble-mux zeroes control into ID/EX.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- idex_en  out  1  ID/EX register load enable.
- ifid_flush  out  1  clear IF/ID to NOP on the next edge.
- bubble_cnt  out  CNT_W  count of cycles with cu_mux_sel=1 (post-reset), saturating.

Behaviour:
- Hazard term: hz = ex_load & ex_rf_en & ((id_use_rn & id_rn==ex_rd) | (id_use_rm & id_rm==ex_rd) | (id_use_rd & id_rd==ex_rd)).
- FSM states: RUN, STALL. STALL holds a 3-bit remaining-bubble counter rem.
- Outputs are combinational from state and inputs. State, rem and bubble_cnt are registered.
- Priority each cycle: reset > mem_wait > (STALL or hz) > branch_taken > normal.
- reset asserted (asynchronous): state=RUN, rem=0, bubble_cnt=0. While reset is high: cu_mux_sel=1, pc_en=0, ifid_en=0, idex_en=0, ifid_flush=0.
- mem_wait=1, any state: pc_en=0, ifid_en=0, idex_en=0, cu_mux_sel=0, ifid_flush=0. State, rem and bubble_cnt are held; a STALL resumes exactly where it left off.
- RUN, hz=1: cu_mux_sel=1, pc_en=0, ifid_en=0, idex_en=1, ifid_flush=0.
  - If LOAD_USE_CYCLES>1: next state STALL, rem=LOAD_USE_CYCLES-1.
  - Otherwise stay in RUN.
  - branch_taken in the same cycle is ignored; the branch stays in ID and is re-evaluated after the stall.
- STALL (no mem_wait): same outputs as the hz case. rem decrements each cycle; when rem==1 on an edge, next state is RUN. hz is not re-evaluated inside STALL.
- RUN, hz=0, branch_taken=1: pc_en=1, ifid_en=1, idex_en=1, cu_mux_sel=0, ifid_flush=1. The wrong-path fetch is squashed in one cycle. Consecutive taken branches each flush.
- RUN, nothing pending: pc_en=ifid_en=idex_en=1, cu_mux_sel=0, ifid_flush=0.
- bubble_cnt increments on every edge where cu_mux_sel=1 and reset=0. It saturates at all-ones and does not wrap. Bubbles driven during reset are not counted.
- Register x0 has no special treatment (ARM r0 is a real register); ex_rd==id_rn matching r0 does stall.
- Reset mid-STALL aborts immediately to RUN; the first post-reset cycle, if hz=0, is normal run.

Test Plan:
- Load-use stall: ex_load=1, ex_rf_en=1, ex_rd=3, id_rn=3, id_use_rn=1, default params -> exactly 1 cycle with cu_mux_sel=1, pc_en=0, ifid_en=0. Next cycle (ex_load=0) normal. bubble_cnt=1.
- No hazard: same as above but ex_rf_en=0 or id_use_rn=0 -> no stall. Store source: id_use_rd=1, id_rd=3 -> stall.
- Multi-bubble with interruption: LOAD_USE_CYCLES=3, hz pulse, then mem_wait=1 for 2 cycles in the second bubble -> 3 bubble cycles total, all enables 0 during the wait, bubble_cnt=3.
- Branch flush: branch_taken=1, hz=0 -> ifid_flush=1 for 1 cycle with pc_en=1. Branch_taken=1 with hz=1 -> ifid_flush=0, stall first; flush occurs the cycle after the stall ends.
- Reset behaviour: assert reset asynchronously mid-STALL (LOAD_USE_CYCLES=4) -> outputs go to reset values immediately, bubble_cnt=0, and the first cycle after deassert is normal run.
- Counter saturation: CNT_W=4, force 20 bubble cycles -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage ARM-subset pipe.
//
// Decodes load-use hazards between the ID and EX stages and inserts a
// programmable number of bubbles. It freezes the whole pipe while data memory
// is busy and squashes the wrong-path IF/ID fetch on taken branches. A
// saturating counter records how many cycles carried a bubble.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   id_rn/id_rm/id_rd          ID-stage source registers (id_rd for stores)
//   id_use_rn/_rm/_rd          source-valid qualifiers
//   ex_load, ex_rf_en, ex_rd   EX-stage load / RF write / destination
//   branch_taken               ID-stage branch resolved taken
//   mem_wait                   data memory not ready, freeze pipe
//   cu_mux_sel                 1 = zero control into ID/EX (bubble)
//   pc_en, ifid_en, idex_en    pipeline register load enables
//   ifid_flush                 clear IF/ID to NOP on next edge
//   bubble_cnt                 saturating count of bubble cycles
module hazard_ctrl #(
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic [3:0]       id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic             ex_load,
    input  logic             ex_rf_en,
    input  logic [3:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             cu_mux_sel,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int unsigned REM_W = 3;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [REM_W-1:0]   r_rem;
    logic [REM_W-1:0]   w_rem_nxt;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic               w_hz;

    // Load-use hazard: r0 is a real register, so no zero-register exclusion.
    assign w_hz = ex_load & ex_rf_en &
                  ((id_use_rn & (id_rn == ex_rd)) |
                   (id_use_rm & (id_rm == ex_rd)) |
                   (id_use_rd & (id_rd == ex_rd)));

    // State and remaining-bubble register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next state and combinational pipe controls, in priority order.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        cu_mux_sel  = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;

        if (reset) begin
            cu_mux_sel = 1'b1;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
        end else if (mem_wait) begin
            // Full freeze; STALL progress is held and resumes afterwards.
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
        end else if (r_state == STALL) begin
            cu_mux_sel = 1'b1;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            if (r_rem == REM_W'(1)) begin
                w_state_nxt = RUN;
                w_rem_nxt   = '0;
            end else begin
                w_rem_nxt = r_rem - REM_W'(1);
            end
        end else if (w_hz) begin
            // A same-cycle taken branch waits in ID and is re-seen later.
            cu_mux_sel = 1'b1;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            if (LOAD_USE_CYCLES > 1) begin
                w_state_nxt = STALL;
                w_rem_nxt   = REM_W'(LOAD_USE_CYCLES - 1);
            end
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // Saturating bubble counter; bubbles shown during reset are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (cu_mux_sel && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Three instances share one input bundle:
// d1 (defaults), d3 (3 bubbles, 4-bit counter), d4 (4 bubbles). Each phase
// resets and targets one instance; expected outputs are queued per cycle.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] id_rn, id_rm, id_rd, ex_rd;
    logic       id_use_rn, id_use_rm, id_use_rd;
    logic       ex_load, ex_rf_en, branch_taken, mem_wait;

    logic        mux1, pc1, ifid1, idex1, fl1;
    logic        mux3, pc3, ifid3, idex3, fl3;
    logic        mux4, pc4, ifid4, idex4, fl4;
    logic [15:0] cnt1, cnt4;
    logic [3:0]  cnt3;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(16)) d1 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .ex_load(ex_load), .ex_rf_en(ex_rf_en), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .cu_mux_sel(mux1), .pc_en(pc1), .ifid_en(ifid1), .idex_en(idex1),
        .ifid_flush(fl1), .bubble_cnt(cnt1));

    hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(4)) d3 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .ex_load(ex_load), .ex_rf_en(ex_rf_en), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .cu_mux_sel(mux3), .pc_en(pc3), .ifid_en(ifid3), .idex_en(idex3),
        .ifid_flush(fl3), .bubble_cnt(cnt3));

    hazard_ctrl #(.LOAD_USE_CYCLES(4), .CNT_W(16)) d4 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
        .ex_load(ex_load), .ex_rf_en(ex_rf_en), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_wait(mem_wait),
        .cu_mux_sel(mux4), .pc_en(pc4), .ifid_en(ifid4), .idex_en(idex4),
        .ifid_flush(fl4), .bubble_cnt(cnt4));

    // Output vector order: {cu_mux_sel, pc_en, ifid_en, idex_en, ifid_flush}
    localparam logic [4:0] O_RST = 5'b10000;
    localparam logic [4:0] O_RUN = 5'b01110;
    localparam logic [4:0] O_BUB = 5'b10010;
    localparam logic [4:0] O_FRZ = 5'b00000;
    localparam logic [4:0] O_FLS = 5'b01111;

    typedef struct {
        int          dut;
        logic [4:0]  o;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rn = '0; id_rm = '0; id_rd = '0; ex_rd = '0;
        id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
        ex_load = 1'b0; ex_rf_en = 1'b0; branch_taken = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic expect_o(input string name, input int dut,
                            input logic [4:0] o, input logic [15:0] cnt);
        exp_t e;
        e.dut = dut; e.o = o; e.cnt = cnt; e.name = name;
        sb.push_back(e);
    endtask

    task automatic load_hz(input logic [3:0] r);
        ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = r; id_rn = r; id_use_rn = 1'b1;
    endtask

    // Monitor: compare the selected instance against the oldest expectation.
    initial begin
        exp_t        e;
        logic [4:0]  act;
        logic [15:0] acnt;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.dut)
                    1:       begin act = {mux1, pc1, ifid1, idex1, fl1}; acnt = cnt1; end
                    3:       begin act = {mux3, pc3, ifid3, idex3, fl3}; acnt = 16'(cnt3); end
                    default: begin act = {mux4, pc4, ifid4, idex4, fl4}; acnt = cnt4; end
                endcase
                checks++;
                if (act !== e.o || acnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s d%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                             e.name, e.dut, act, acnt, e.o, e.cnt);
                end
            end
        end
    end

    initial begin
        clr();
        // Phase A: default instance
        tick(); expect_o("a_rst", 1, O_RST, 0);
        tick(); reset = 1'b0; expect_o("a_idle", 1, O_RUN, 0);
        tick(); load_hz(4'd3); expect_o("a_lu", 1, O_BUB, 0);
        tick(); ex_load = 1'b0; expect_o("a_lu_after", 1, O_RUN, 1);
        tick(); clr(); load_hz(4'd3); ex_rf_en = 1'b0; expect_o("a_no_rfen", 1, O_RUN, 1);
        tick(); ex_rf_en = 1'b1; id_use_rn = 1'b0; expect_o("a_no_use", 1, O_RUN, 1);
        tick(); id_use_rd = 1'b1; id_rd = 4'd3; id_rn = 4'd7; expect_o("a_store", 1, O_BUB, 1);
        tick(); clr(); expect_o("a_store_after", 1, O_RUN, 2);
        tick(); ex_load = 1'b1; ex_rf_en = 1'b1; ex_rd = 4'd0; id_rm = 4'd0;
        id_use_rm = 1'b1; expect_o("a_r0", 1, O_BUB, 2);
        tick(); clr(); expect_o("a_r0_after", 1, O_RUN, 3);
        tick(); branch_taken = 1'b1; expect_o("a_br1", 1, O_FLS, 3);
        tick(); expect_o("a_br2", 1, O_FLS, 3);
        tick(); load_hz(4'd5); expect_o("a_br_hz", 1, O_BUB, 3);
        tick(); ex_load = 1'b0; expect_o("a_br_late", 1, O_FLS, 4);
        tick(); clr(); expect_o("a_idle2", 1, O_RUN, 4);
        tick(); load_hz(4'd9); mem_wait = 1'b1; expect_o("a_mw_hz", 1, O_FRZ, 4);
        tick(); clr(); expect_o("a_mw_after", 1, O_RUN, 4);

        // Phase B: three bubbles with a two-cycle memory wait, then saturation
        tick(); reset = 1'b1; expect_o("b_rst", 3, O_RST, 0);
        tick(); reset = 1'b0; expect_o("b_idle", 3, O_RUN, 0);
        tick(); load_hz(4'd2); expect_o("b_bub1", 3, O_BUB, 0);
        tick(); clr(); mem_wait = 1'b1; expect_o("b_wait1", 3, O_FRZ, 1);
        tick(); expect_o("b_wait2", 3, O_FRZ, 1);
        tick(); mem_wait = 1'b0; expect_o("b_bub2", 3, O_BUB, 1);
        tick(); expect_o("b_bub3", 3, O_BUB, 2);
        tick(); expect_o("b_done", 3, O_RUN, 3);
        tick(); load_hz(4'd6);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            expect_o("b_sat", 3, O_BUB, ((3 + k) > 15) ? 16'd15 : 16'(3 + k));
        end
        tick(); clr(); expect_o("b_sat_tail", 3, O_BUB, 15);
        tick(); expect_o("b_sat_hold", 3, O_RUN, 15);

        // Phase C: asynchronous reset in the middle of a four-bubble stall
        tick(); reset = 1'b1; expect_o("c_rst", 4, O_RST, 0);
        tick(); reset = 1'b0; expect_o("c_idle", 4, O_RUN, 0);
        tick(); load_hz(4'd1); expect_o("c_bub1", 4, O_BUB, 0);
        tick(); clr(); expect_o("c_bub2", 4, O_BUB, 1);
        tick(); reset = 1'b1; expect_o("c_rst_mid", 4, O_RST, 0);
        tick(); reset = 1'b0; expect_o("c_post_rst", 4, O_RUN, 0);
        tick(); branch_taken = 1'b1; expect_o("c_post_br", 4, O_FLS, 0);
        tick(); clr();

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
